// File: rtl/mult_seq_64x64.sv
// 64x64 multiplier sequenced over one 32x32 hard multiplier (four partial products, 128-bit accumulate).
// Define MULT_SEQ_64X64_SIGNED_EN for two's-complement operands (adds one CORR cycle).
module mult_seq_64x64 (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_a,
    input  logic [63:0]  in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_p,
    output logic [31:0]  mult_a,
    output logic [31:0]  mult_b,
    output logic         mult_valid,
    input  logic [63:0]  mult_c
);

`ifdef MULT_SEQ_64X64_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PP0, S_PP1, S_PP2, S_PP3, S_CORR, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PP0, S_PP1, S_PP2, S_PP3, S_DONE
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [63:0]    a_q, a_d;
    logic [63:0]    b_q, b_d;
    logic [127:0]   acc_q, acc_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [6:0]     pp_shift;

    function automatic logic [127:0] pp_term(input logic [63:0] c, input logic [6:0] shift);
        return {64'b0, c} << shift;
    endfunction

`ifdef MULT_SEQ_64X64_SIGNED_EN
    // Unsigned product of the raw bit patterns overshoots the signed one by these sign-weighted terms.
    function automatic logic [127:0] corr_term(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] t;
        t = '0;
        if (a[63]) t = t + {b, 64'b0};
        if (b[63]) t = t + {a, 64'b0};
        return t;
    endfunction
`endif

    always_comb begin
        mult_valid = 1'b0;
        mult_a     = '0;
        mult_b     = '0;
        pp_shift   = '0;
        case (state_q)
            S_PP0: begin
                mult_valid = 1'b1;
                mult_a     = a_q[31:0];
                mult_b     = b_q[31:0];
                pp_shift   = 7'd0;
            end
            S_PP1: begin
                mult_valid = 1'b1;
                mult_a     = a_q[31:0];
                mult_b     = b_q[63:32];
                pp_shift   = 7'd32;
            end
            S_PP2: begin
                mult_valid = 1'b1;
                mult_a     = a_q[63:32];
                mult_b     = b_q[31:0];
                pp_shift   = 7'd32;
            end
            S_PP3: begin
                mult_valid = 1'b1;
                mult_a     = a_q[63:32];
                mult_b     = b_q[63:32];
                pp_shift   = 7'd64;
            end
            default: begin
                mult_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    state_d = S_PP0;
                end
            end
            S_PP0: begin
                acc_d   = acc_q + pp_term(mult_c, pp_shift);
                state_d = S_PP1;
            end
            S_PP1: begin
                acc_d   = acc_q + pp_term(mult_c, pp_shift);
                state_d = S_PP2;
            end
            S_PP2: begin
                acc_d   = acc_q + pp_term(mult_c, pp_shift);
                state_d = S_PP3;
            end
            S_PP3: begin
                acc_d   = acc_q + pp_term(mult_c, pp_shift);
`ifdef MULT_SEQ_64X64_SIGNED_EN
                state_d = S_CORR;
`else
                state_d = S_DONE;
`endif
            end
`ifdef MULT_SEQ_64X64_SIGNED_EN
            S_CORR: begin
                acc_d   = acc_q - corr_term(a_q, b_q);
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up with state_q.
    assign in_ready_d  = (state_d == S_IDLE);
    assign out_valid_d = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = acc_q;

endmodule

// File: tb/tb_mult_seq_64x64.sv
// Self-checking bench for mult_seq_64x64: directed vector table, reset abort, and random back-to-back traffic.
module tb_mult_seq_64x64;

`ifdef MULT_SEQ_64X64_SIGNED_EN
    localparam int LAT    = 6;
`else
    localparam int LAT    = 5;
`endif
    localparam int PERIOD = LAT + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_a;
    logic [63:0]  in_b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_p;
    logic [31:0]  mult_a;
    logic [31:0]  mult_b;
    logic         mult_valid;
    logic [63:0]  mult_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the hard 32x32 multiplier.
    assign mult_c = mult_valid ? ({32'b0, mult_a} * {32'b0, mult_b}) : 64'b0;

    mult_seq_64x64 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_valid (mult_valid),
        .mult_c     (mult_c)
    );

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
`ifdef MULT_SEQ_64X64_SIGNED_EN
        logic signed [127:0] sa, sb;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        return sa * sb;
`else
        return {64'b0, a} * {64'b0, b};
`endif
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one operation from IDLE; caller is positioned #1 after a clock edge.
    task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp, input int stall);
        logic [15:0]  mask;
        logic [127:0] p0;
        int           lat;
        bit           ok;
        out_ready = 1'b0;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = a ^ b ^ 64'h5A5A_5A5A_1234_5678;
        mask = '0;
        lat  = 0;
        for (int c = 1; c <= 12; c++) begin
            if (mult_valid) mask[c] = 1'b1;
            if (out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_latency"}, 128'(lat), 128'(LAT));
        chk({nm, "_mvalid_cycles"}, 128'(mask), 128'h1E);
        chk({nm, "_p"}, out_p, exp);
        ok = 1'b1;
        p0 = out_p;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (out_p !== p0 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        end
        if (stall > 0) chk({nm, "_stall_stable"}, 128'(ok), 128'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_back_idle"}, {126'b0, in_ready, out_valid}, 128'b10);
    endtask

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
        int           stall;
    } vec_t;

    vec_t        vecs[6];
    logic [127:0] q[$];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;

        vecs[0] = '{64'h0, 64'h0, 128'h0, 0};
        vecs[2] = '{64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
                    128'h3_0000000A_00000008, 10};
        vecs[3] = '{64'd7, 64'd6, 128'd42, 0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000, 2};
`ifdef MULT_SEQ_64X64_SIGNED_EN
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1, 0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
                    128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFA, 0};
`else
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFFFFFFFFFFFFFE_0000000000000001, 0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
                    128'h2_FFFFFFFF_FFFFFFFA, 0};
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_p", out_p, 128'd0);
        chk("rst_mult_valid", 128'(mult_valid), 128'd0);
        chk("rst_mult_ab", {64'b0, mult_a, mult_b}, 128'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall);

        // Abort an operation in PP2 with reset, then confirm no residue.
        in_a     = 64'hDEAD_BEEF_CAFE_F00D;
        in_b     = 64'h1234_5678_9ABC_DEF0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pp2_mvalid", 128'(mult_valid), 128'd1);
        chk("pp2_mult_ab", {64'b0, mult_a, mult_b}, {64'b0, 32'hDEAD_BEEF, 32'h9ABC_DEF0});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_flags", {125'b0, in_ready, out_valid, mult_valid}, 128'b100);
        run_op("after_abort", 64'd7, 64'd6, 128'd42, 0);

        // Back-to-back random traffic with in_valid and out_ready held high.
        begin
            int acc_n = 0, res_n = 0, mv_n = 0, sp_bad = 0, last = -1;
            bit took;
            in_a      = rand64();
            in_b      = rand64();
            in_valid  = 1'b1;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 3000 && res_n < 100; cyc++) begin
                @(negedge clk);
                if (mult_valid) mv_n++;
                if (out_valid) begin
                    if (q.size() == 0) chk("rand_unexpected_result", out_p, 128'hX);
                    else chk($sformatf("rand_p%0d", res_n), out_p, q.pop_front());
                    res_n++;
                end
                took = 1'b0;
                if (in_valid && in_ready) begin
                    q.push_back(ref_mul(in_a, in_b));
                    if (last >= 0 && cyc - last != PERIOD) sp_bad++;
                    last = cyc;
                    acc_n++;
                    took = 1'b1;
                end
                @(posedge clk); #1;
                if (took) begin
                    if (acc_n >= 100) in_valid = 1'b0;
                    else begin
                        in_a = rand64();
                        in_b = rand64();
                    end
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("rand_results", 128'(res_n), 128'd100);
            chk("rand_accepts", 128'(acc_n), 128'd100);
            chk("rand_accept_spacing", 128'(sp_bad), 128'd0);
            chk("rand_mvalid_cycles", 128'(mv_n), 128'd400);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq_64x64.md
# mult_seq_64x64

Sequencing initiator for the 32x32 hard multiplier wrapper (`MULT_32BIT`). It accepts 64x64 operand pairs over a valid/ready handshake and issues four 32x32 partial-product requests to the hard multiplier, one per cycle. It accumulates the returned 64-bit partial products into a 128-bit result and presents that result over a valid/ready handshake. It sits between fabric datapath logic and one `MULT_32BIT` instance, so wide multiplies can use a single hard block.

## Interface
Parameters: none; all widths are fixed by the hard-multiplier interface.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  64  multiplicand
- in_b  in  64  multiplier
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_p  out  128  product
- mult_a  out  32  to `MULT_32BIT` `Amult`
- mult_b  out  32  to `MULT_32BIT` `Bmult`
- mult_valid  out  1  to `MULT_32BIT` `Valid_mult`
- mult_c  in  64  from `MULT_32BIT` `Cmult`; combinational in the same cycle as `mult_a`/`mult_b`

## Operation
- States: IDLE, PP0, PP1, PP2, PP3, CORR (only with the macro), DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `in_a`/`in_b` into operand registers, clear the 128-bit accumulator, and go to PP0.
- PPn (n=0..3):
  - `mult_valid`=1.
  - Drive `mult_a`/`mult_b` with the following halves:
    - PP0: A[31:0]*B[31:0], shift 0
    - PP1: A[31:0]*B[63:32], shift 32
    - PP2: A[63:32]*B[31:0], shift 32
    - PP3: A[63:32]*B[63:32], shift 64
  - At the end of the cycle, accumulator += zero-extended `mult_c` << shift, modulo 2^128.
  - PPn→PPn+1; PP3→CORR if configured, else DONE.
- CORR: applies the signed correction (see Configuration), then goes to DONE.
- DONE:
  - `out_valid`=1 and `out_p`=accumulator.
  - While `out_ready`=0, hold state; `out_p` stays stable.
  - When `out_ready`=1, go to IDLE next cycle.
- Outside PP states: `mult_valid`=0 and `mult_a`=`mult_b`=0.
- `in_ready`=1 only in IDLE. Operands are never accepted in the same cycle a result is delivered.
- Changes to `in_a`/`in_b` after acceptance have no effect.

## Timing
- Reset values:
  - state=IDLE
  - `in_ready`=1 (the first cycle after reset is released)
  - `out_valid`=0, `out_p`=0
  - `mult_valid`=0, `mult_a`=0, `mult_b`=0
  - accumulator=0
- Latency, counted from the accept edge (cycle 0):
  - PP0..PP3 occupy cycles 1–4.
  - `out_valid` rises in cycle 5, or cycle 6 with the macro.
- Throughput: one product per 6 cycles (7 with the macro) when `out_ready` is held high. This counts the return cycle through IDLE.
- Reset asserted in any state: next cycle is IDLE; the partial result is discarded and `out_valid`=0. No output handshake completes for the aborted operation.
- `in_valid` asserted while not in IDLE: ignored; the producer holds it.
- All outputs are registered except `mult_a`/`mult_b`/`mult_valid`, which decode from registered state and operands.

## Configuration
- Macro: `MULT_SEQ_64X64_SIGNED_EN`.
- Defined:
  - Operands are two's-complement, and `out_p` is the signed 128-bit product.
  - The CORR state executes: accumulator -= (A[63] ? B<<64 : 0) + (B[63] ? A<<64 : 0), modulo 2^128.
  - Latency is 6 cycles.
- Undefined:
  - Operands are unsigned.
  - The CORR state does not exist and PP3 goes directly to DONE.
  - Latency is 5 cycles.
- The hard-multiplier request sequence is identical in both builds.

## Test plan
- Unsigned, A=B=0xFFFFFFFF_FFFFFFFF -> `out_p`=0xFFFFFFFFFFFFFFFE_0000000000000001. `out_valid` rises 5 cycles after acceptance, and `mult_valid` is high for exactly cycles 1–4.
- A=0x00000001_00000002, B=0x00000003_00000004, `out_ready` held low 10 cycles -> `out_p`=0x3_0000000A_00000008. The value is stable throughout the stall, `in_ready`=0 throughout, and the block returns to IDLE one cycle after `out_ready` rises.
- Signed build, A=-1, B=-1 -> `out_p`=1. Signed build, A=-2, B=3 -> `out_p`=0xFFFF…FFFA (all 128 bits). Latency is 6 cycles.
- Reset pulsed during PP2 -> next cycle IDLE with `out_valid`=0 and `mult_valid`=0. A following operation with A=7, B=6 yields 42 with no residue from the aborted operation.
- Back-to-back ops with `in_valid` held high and `out_ready` high: 100 random operand pairs are checked against a 128-bit reference model. There is exactly one accept per 6 cycles (7 in the signed build), and no accept ever occurs while `in_ready`=0.
